// File: rtl/tail_light_monitor.sv
// Passive checker for the turn-signal tail-light bus: decodes direction/phase,
// counts completed sweeps, and flags illegal, out-of-order, dwell and request errors.
module tail_light_monitor #(
    parameter int unsigned DWELL = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       lights,
    input  logic             left,
    input  logic             right,
    output logic [1:0]       dir,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] left_cycles,
    output logic [CNT_W-1:0] right_cycles,
    output logic             seq_error,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3
    } state_t;

    localparam logic [3:0] W_DWELL = DWELL[3:0];

    state_t           r_state, w_next, w_enc;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_left_cycles, r_right_cycles, r_err_count;
    logic             r_seq_error;
    logic [2:0]       r_err_code;

    logic             w_legal;
    logic [5:0]       w_cur_pat, w_exp_pat;
    logic             w_err;
    logic [2:0]       w_code;
    logic             w_inc_l, w_inc_r;

    // Pattern decode: which state the sampled lamps encode, if any.
    always_comb begin
        w_legal = 1'b1;
        w_enc   = S_IDLE;
        case (lights)
            6'b000000: w_enc = S_IDLE;
            6'b001000: w_enc = S_L1;
            6'b011000: w_enc = S_L2;
            6'b111000: w_enc = S_L3;
            6'b000100: w_enc = S_R1;
            6'b000110: w_enc = S_R2;
            6'b000111: w_enc = S_R3;
            default:   w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_cur_pat = 6'b000000;
        w_exp_pat = 6'b000000;
        dir       = 2'b00;
        phase     = 2'd0;
        case (r_state)
            S_L1: begin w_cur_pat = 6'b001000; w_exp_pat = 6'b011000; dir = 2'b01; phase = 2'd1; end
            S_L2: begin w_cur_pat = 6'b011000; w_exp_pat = 6'b111000; dir = 2'b01; phase = 2'd2; end
            S_L3: begin w_cur_pat = 6'b111000; w_exp_pat = 6'b000000; dir = 2'b01; phase = 2'd3; end
            S_R1: begin w_cur_pat = 6'b000100; w_exp_pat = 6'b000110; dir = 2'b10; phase = 2'd1; end
            S_R2: begin w_cur_pat = 6'b000110; w_exp_pat = 6'b000111; dir = 2'b10; phase = 2'd2; end
            S_R3: begin w_cur_pat = 6'b000111; w_exp_pat = 6'b000000; dir = 2'b10; phase = 2'd3; end
            default: ;
        endcase
    end

    // Next state; every error path resyncs to whatever the lamps encode.
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_err     = 1'b0;
        w_code    = 3'b000;
        w_inc_l   = 1'b0;
        w_inc_r   = 1'b0;
        if (!w_legal) begin
            w_err     = 1'b1;
            w_code    = 3'b001;
            w_next    = S_IDLE;
            w_cnt_nxt = 4'd0;
        end else if (r_state == S_IDLE) begin
            if (w_enc != S_IDLE) begin
                w_next    = w_enc;
                w_cnt_nxt = 4'd1;
                if (w_enc != S_L1 && w_enc != S_R1) begin
                    w_err  = 1'b1;
                    w_code = 3'b010;
                end else if ((w_enc == S_L1 && !left) || (w_enc == S_R1 && !right)) begin
                    w_err  = 1'b1;
                    w_code = 3'b100;
                end
            end
        end else if (lights == w_cur_pat) begin
            if (r_cnt == W_DWELL) begin
                w_err     = 1'b1;
                w_code    = 3'b011;
                w_cnt_nxt = 4'd1;
            end else begin
                w_cnt_nxt = r_cnt + 4'd1;
            end
        end else begin
            w_next    = w_enc;
            w_cnt_nxt = (w_enc == S_IDLE) ? 4'd0 : 4'd1;
            if (lights != w_exp_pat) begin
                w_err  = 1'b1;
                w_code = 3'b010;
            end else if (r_cnt != W_DWELL) begin
                w_err  = 1'b1;
                w_code = 3'b011;
            end else begin
                w_inc_l = (r_state == S_L3);
                w_inc_r = (r_state == S_R3);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_left_cycles  <= '0;
            r_right_cycles <= '0;
            r_err_count    <= '0;
            r_seq_error    <= 1'b0;
            r_err_code     <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_nxt;
            r_seq_error <= w_err;
            if (w_inc_l) r_left_cycles  <= r_left_cycles + CNT_W'(1);
            if (w_inc_r) r_right_cycles <= r_right_cycles + CNT_W'(1);
            if (w_err) begin
                r_err_code <= w_code;
                if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign left_cycles  = r_left_cycles;
    assign right_cycles = r_right_cycles;
    assign err_count    = r_err_count;
    assign seq_error    = r_seq_error;
    assign err_code     = r_err_code;

endmodule

// File: tb/tb_tail_light_monitor.sv
// Bench for tail_light_monitor: DWELL=1 and DWELL=2 instances share one stimulus
// stream and are compared every cycle against a side/phase arithmetic model.
module tb_tail_light_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] lights = 6'b000000;
    logic       left = 1'b0;
    logic       right = 1'b0;

    logic [1:0] dir0, phase0, dir1, phase1;
    logic [7:0] lc0, rc0, ec0, lc1, rc1, ec1;
    logic       se0, se1;
    logic [2:0] code0, code1;

    int checks = 0;
    int failures = 0;

    // Model state per instance: side 0 idle / 1 left / 2 right, phase = lamps lit.
    int m_side[2], m_ph[2], m_cnt[2], m_lc[2], m_rc[2], m_code[2], m_ecnt[2], m_err[2];
    int dwell[2] = '{1, 2};

    always #5 Clk = ~Clk;

    tail_light_monitor #(.DWELL(1), .CNT_W(8)) u_d1 (
        .Clk(Clk), .Reset(Reset), .lights(lights), .left(left), .right(right),
        .dir(dir0), .phase(phase0), .left_cycles(lc0), .right_cycles(rc0),
        .seq_error(se0), .err_code(code0), .err_count(ec0)
    );

    tail_light_monitor #(.DWELL(2), .CNT_W(8)) u_d2 (
        .Clk(Clk), .Reset(Reset), .lights(lights), .left(left), .right(right),
        .dir(dir1), .phase(phase1), .left_cycles(lc1), .right_cycles(rc1),
        .seq_error(se1), .err_code(code1), .err_count(ec1)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_side[k] = 0; m_ph[k] = 0; m_cnt[k] = 0; m_lc[k] = 0;
            m_rc[k] = 0; m_code[k] = 0; m_ecnt[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic decode(input logic [5:0] p, output bit ok, output int side, output int ph);
        logic [2:0] lh, rh;
        lh = p[5:3];
        rh = p[2:0];
        ok = 1'b1; side = 0; ph = 0;
        if (p == 6'd0) begin
            ok = 1'b1;
        end else if (rh == 3'b000 && (lh == 3'b001 || lh == 3'b011 || lh == 3'b111)) begin
            side = 1; ph = $countones(lh);
        end else if (lh == 3'b000 && (rh == 3'b100 || rh == 3'b110 || rh == 3'b111)) begin
            side = 2; ph = $countones(rh);
        end else begin
            ok = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [5:0] p, input logic l, input logic r);
        bit ok;
        int ps, pp, e;
        bit move;
        e = 0;
        move = 1'b0;
        decode(p, ok, ps, pp);
        if (!ok) begin
            e = 1; ps = 0; pp = 0; move = 1'b1;
        end else if (m_ph[k] == 0) begin
            if (pp == 1) begin
                if ((ps == 1 && !l) || (ps == 2 && !r)) e = 4;
            end else if (pp != 0) begin
                e = 2;
            end
            move = 1'b1;
        end else if (ps == m_side[k] && pp == m_ph[k]) begin
            if (m_cnt[k] == dwell[k]) begin
                e = 3; m_cnt[k] = 1;
            end else begin
                m_cnt[k]++;
            end
        end else if ((ps == m_side[k] && pp == m_ph[k] + 1) || (m_ph[k] == 3 && pp == 0)) begin
            if (m_cnt[k] != dwell[k]) e = 3;
            else if (m_ph[k] == 3 && m_side[k] == 1) m_lc[k] = (m_lc[k] + 1) % 256;
            else if (m_ph[k] == 3 && m_side[k] == 2) m_rc[k] = (m_rc[k] + 1) % 256;
            move = 1'b1;
        end else begin
            e = 2; move = 1'b1;
        end
        if (move) begin
            m_side[k] = ps; m_ph[k] = pp; m_cnt[k] = (pp == 0) ? 0 : 1;
        end
        m_err[k] = (e != 0);
        if (e != 0) begin
            m_code[k] = e;
            if (m_ecnt[k] < 255) m_ecnt[k]++;
        end
    endtask

    task automatic compare_all();
        check("d1.dir", dir0, m_side[0]);
        check("d1.phase", phase0, m_ph[0]);
        check("d1.left_cycles", lc0, m_lc[0]);
        check("d1.right_cycles", rc0, m_rc[0]);
        check("d1.seq_error", se0, m_err[0]);
        check("d1.err_code", code0, m_code[0]);
        check("d1.err_count", ec0, m_ecnt[0]);
        check("d2.dir", dir1, m_side[1]);
        check("d2.phase", phase1, m_ph[1]);
        check("d2.left_cycles", lc1, m_lc[1]);
        check("d2.right_cycles", rc1, m_rc[1]);
        check("d2.seq_error", se1, m_err[1]);
        check("d2.err_code", code1, m_code[1]);
        check("d2.err_count", ec1, m_ecnt[1]);
    endtask

    task automatic step(input logic [5:0] p, input logic l, input logic r);
        lights = p; left = l; right = r;
        @(posedge Clk);
        model_step(0, p, l, r);
        model_step(1, p, l, r);
        #1;
        compare_all();
    endtask

    task automatic left_sweep(input int hold);
        for (int h = 0; h < hold; h++) step(6'b001000, 1'b1, 1'b0);
        for (int h = 0; h < hold; h++) step(6'b011000, 1'b1, 1'b0);
        for (int h = 0; h < hold; h++) step(6'b111000, 1'b1, 1'b0);
        step(6'b000000, 1'b0, 1'b0);
    endtask

    task automatic right_sweep();
        step(6'b000100, 1'b0, 1'b1);
        step(6'b000110, 1'b0, 1'b1);
        step(6'b000111, 1'b0, 1'b1);
        step(6'b000000, 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] legal_tab[7];
        logic [5:0] gen_pat;
        int gside, gph, ghold;
        legal_tab = '{6'b000000, 6'b001000, 6'b011000, 6'b111000,
                      6'b000100, 6'b000110, 6'b000111};
        model_reset();
        #1;
        check("reset.d1.dir", dir0, 0);
        check("reset.d1.err_count", ec0, 0);
        #8 Reset = 1'b1;

        // Idle, then one clean left sweep.
        for (int i = 0; i < 3; i++) step(6'b000000, 1'b0, 1'b0);
        left_sweep(1);
        check("t2.d1.left_cycles", lc0, 1);
        check("t2.d1.err_count", ec0, 0);

        // Two right sweeps, then a right step without the request.
        right_sweep();
        right_sweep();
        check("t3.d1.right_cycles", rc0, 2);
        step(6'b000100, 1'b0, 1'b0);
        check("t3.d1.seq_error", se0, 1);
        check("t3.d1.err_code", code0, 3'b100);
        check("t3.d1.err_count", ec0, 1);
        check("t3.d1.dir", dir0, 2'b10);
        check("t3.d1.phase", phase0, 1);
        step(6'b000000, 1'b0, 1'b0);

        // Illegal pattern in L2, then an out-of-order jump from L1 to L3.
        step(6'b001000, 1'b1, 1'b0);
        step(6'b011000, 1'b1, 1'b0);
        step(6'b111100, 1'b1, 1'b0);
        check("t4.d1.err_code", code0, 3'b001);
        check("t4.d1.dir", dir0, 0);
        check("t4.d1.left_cycles", lc0, 1);
        step(6'b001000, 1'b1, 1'b0);
        step(6'b111000, 1'b1, 1'b0);
        check("t4.d1.err_code_ooo", code0, 3'b010);
        check("t4.d1.phase", phase0, 3);
        step(6'b000000, 1'b0, 1'b0);
        step(6'b000000, 1'b0, 1'b0);

        // Dwell violations for the DWELL=2 instance, then a clean slow sweep.
        step(6'b001000, 1'b1, 1'b0);
        step(6'b011000, 1'b1, 1'b0);
        check("t5.d2.short_dwell", code1, 3'b011);
        step(6'b000000, 1'b0, 1'b0);
        step(6'b000000, 1'b0, 1'b0);
        step(6'b001000, 1'b1, 1'b0);
        step(6'b001000, 1'b1, 1'b0);
        check("t5.d2.no_err_at_dwell", se1, 0);
        step(6'b001000, 1'b1, 1'b0);
        check("t5.d2.long_dwell", se1, 1);
        check("t5.d2.long_code", code1, 3'b011);
        step(6'b000000, 1'b0, 1'b0);
        left_sweep(2);

        // Randomised traffic: mostly well-formed sweeps, some legal jumps and noise.
        gside = 0; gph = 0; ghold = 0;
        for (int i = 0; i < 800; i++) begin
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                gen_pat = 6'($urandom);
            end else if (sel <= 2) begin
                gen_pat = legal_tab[$urandom_range(0, 6)];
            end else begin
                if (ghold > 0) begin
                    ghold--;
                end else begin
                    if (gph == 0) begin
                        gside = $urandom_range(1, 2); gph = 1;
                    end else if (gph == 3) begin
                        gph = 0;
                    end else begin
                        gph++;
                    end
                    ghold = (gph == 0) ? $urandom_range(0, 2) : $urandom_range(0, 1);
                end
                if (gph == 0) gen_pat = 6'b000000;
                else if (gside == 1) gen_pat = {3'((1 << gph) - 1), 3'b000};
                else gen_pat = {3'b000, 3'(8 - (1 << (3 - gph)))};
            end
            step(gen_pat, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) != 0));
        end

        // Error counter saturation.
        for (int i = 0; i < 260; i++) step(6'b110011, 1'b0, 1'b0);
        check("t5.d1.err_count_sat", ec0, 255);
        check("t5.d2.err_count_sat", ec1, 255);
        step(6'b000000, 1'b0, 1'b0);

        // Asynchronous reset between edges while in L2.
        step(6'b001000, 1'b1, 1'b0);
        step(6'b011000, 1'b1, 1'b0);
        #3 Reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("t6.d1.left_cycles_clr", lc0, 0);
        check("t6.d1.phase_clr", phase0, 0);
        #1 Reset = 1'b1;
        step(6'b000000, 1'b0, 1'b0);
        left_sweep(1);
        check("t6.d1.left_cycles", lc0, 1);
        check("t6.d1.err_count", ec0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
